btn_debounce_bank: RTL and testbench
====================================

Name: btn_debounce_bank

Overview:
- Parametrised debouncer and event reporter for N mechanical push-buttons (BTN_NORTH and siblings) on the 50 MHz board clock.
- Successor to the single hard-wired reset/start button path.
- Per channel: 2-FF synchroniser, debounce FSM, clean level, one-cycle press/release strobes.
- Press events are queued per channel and presented to the CPU/controller through a valid/ack handshake.

Parameters:
- N_BTN, 4, number of button channels (1..16)
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a change (10 ms at 50 MHz); minimum 2
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
- ID_W, 2, event index width; must satisfy 2^ID_W >= N_BTN

Ports:
- inCLK_50MHZ  input  1  system clock, all logic on rising edge
- reset_n  input  1  synchronous active-low reset
- btn_in  input  N_BTN  raw asynchronous button inputs, active-high
- btn_level  output  N_BTN  debounced level per channel
- btn_press  output  N_BTN  one-cycle strobe on accepted 0->1
- btn_release  output  N_BTN  one-cycle strobe on accepted 1->0
- evt_valid  output  1  a press event is pending for the consumer
- evt_id  output  ID_W  channel index of the presented event
- evt_ack  input  1  consumer accepts the presented event
- evt_overflow  output  N_BTN  sticky: channel pressed again while its event was still pending

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - synchronisers, counters, btn_level, btn_press, btn_release, pending bits, evt_valid, evt_id and evt_overflow all go to 0.
  - FSMs go to STABLE_LO.
  - Reset mid-debounce discards partial counts. Reset while evt_valid=1 drops the event.
- Synchroniser: s[i] = btn_in[i] after 2 edges; only s[i] feeds the FSM.
- Per-channel FSM:
  - STABLE_LO: s=1 -> PEND_HI, cnt=1.
  - PEND_HI: s=0 -> STABLE_LO, cnt=0. s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, level=1, press strobe, cnt=0. Otherwise cnt++.
  - STABLE_HI and PEND_LO: mirror of the above; release strobe on entering STABLE_LO.
  - A glitch shorter than DEBOUNCE_CYCLES samples produces no strobe and no level change.
- Latency: a clean edge on btn_in appears on btn_level and its strobe exactly 2+DEBOUNCE_CYCLES rising edges later. Strobes last exactly 1 cycle. Counter saturation is not possible, by construction.
- Event queue:
  - pend[i] is set by btn_press[i].
  - When evt_valid=0 and any pend bit is set, evt_valid rises the next cycle with evt_id = lowest set index.
  - evt_valid and evt_id hold stable until evt_ack=1 with evt_valid=1. That cycle clears pend[evt_id], and evt_valid drops for at least 1 cycle before the next event is presented.
  - evt_ack while evt_valid=0 is ignored.
  - A press on a channel whose pend bit is already set (including the same cycle as its ack) sets evt_overflow[i], cleared only by reset. When a new press and the ack land on the same channel in the same cycle, pend stays set.
- Simultaneous presses on several channels all set their pend bits. They are delivered in ascending index order.

Optional Feature:
- Macro LONG_PRESS_EN.
- Defined:
  - adds parameter LONG_CYCLES (default 50000000, 1 s) and output btn_long [N_BTN].
  - a per-channel counter runs while in STABLE_HI and fires a one-cycle btn_long strobe when it reaches LONG_CYCLES.
  - fires once per hold; the counter clears on leaving STABLE_HI.
- Undefined: no counter logic; btn_long is not present.

Test Plan (N_BTN=4, DEBOUNCE_CYCLES=4, CNT_W=3, ID_W=2):
- Reset then btn_in=0000 for 20 cycles -> all outputs 0, evt_valid=0.
- btn_in[0] 0->1 held -> btn_level[0]=1 and btn_press[0]=1 exactly 6 edges later for 1 cycle; evt_valid=1 next cycle with evt_id=0. Ack -> evt_valid=0.
- btn_in[2] pulses high for 3 cycles, then low -> no strobe, btn_level[2] stays 0, evt_valid stays 0.
- btn_in[3] and btn_in[1] rise on the same cycle -> both press strobes on the same cycle; events presented id=1, then id=3 after ack. Release 0->1->0 cycles later gives one btn_release strobe per channel.
- Press channel 1 twice without ack -> evt_overflow[1]=1, only one event for id 1. Reset_n=0 for 1 cycle mid-PEND_HI on channel 0 -> no strobe, overflow cleared.
- LONG_PRESS_EN with LONG_CYCLES=10: hold btn_in[0] -> btn_long[0] strobes once, 10 cycles after btn_level[0] rises; not again while held.

Source files
------------

// File: rtl/btn_debounce_bank.sv
// N-channel push-button debouncer with press-event queue and valid/ack handshake.
// Optional long-press strobe when LONG_PRESS_EN is defined.
//
// state     | meaning
// STABLE_LO | accepted level 0, waiting for a 1 sample
// PEND_HI   | counting consecutive 1 samples towards a press
// STABLE_HI | accepted level 1, waiting for a 0 sample
// PEND_LO   | counting consecutive 0 samples towards a release
module btn_debounce_bank #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int ID_W            = 2
`ifdef LONG_PRESS_EN
    ,parameter int LONG_CYCLES    = 50000000
`endif
) (
    input  logic             inCLK_50MHZ,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_ack,
    output logic [N_BTN-1:0] evt_overflow
`ifdef LONG_PRESS_EN
    ,output logic [N_BTN-1:0] btn_long
`endif
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } db_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync_a;
    logic [N_BTN-1:0] sync_s;
    db_state_t        state [N_BTN];
    logic [CNT_W-1:0] cnt   [N_BTN];

    logic [N_BTN-1:0] press_acc;
    logic [N_BTN-1:0] ack_clr;
    logic [N_BTN-1:0] pend;
    logic             ack_fire;

`ifdef LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);
    logic [LONG_W-1:0] long_cnt [N_BTN];
`endif

    // Press acceptance is decoded combinationally so the pending bit is set on
    // the same edge as the press strobe.
    always_comb begin
        press_acc = '0;
        for (int i = 0; i < N_BTN; i++) begin
            press_acc[i] = (state[i] == PEND_HI) && sync_s[i] && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge inCLK_50MHZ) begin
        if (!reset_n) begin
            sync_a      <= '0;
            sync_s      <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= STABLE_LO;
                cnt[i]   <= '0;
            end
        end else begin
            sync_a      <= btn_in;
            sync_s      <= sync_a;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                case (state[i])
                    STABLE_LO: begin
                        if (sync_s[i]) begin
                            state[i] <= PEND_HI;
                            cnt[i]   <= CNT_W'(1);
                        end
                    end
                    PEND_HI: begin
                        if (!sync_s[i]) begin
                            state[i] <= STABLE_LO;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]     <= STABLE_HI;
                            cnt[i]       <= '0;
                            btn_level[i] <= 1'b1;
                            btn_press[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    STABLE_HI: begin
                        if (!sync_s[i]) begin
                            state[i] <= PEND_LO;
                            cnt[i]   <= CNT_W'(1);
                        end
                    end
                    PEND_LO: begin
                        if (sync_s[i]) begin
                            state[i] <= STABLE_HI;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]       <= STABLE_LO;
                            cnt[i]         <= '0;
                            btn_level[i]   <= 1'b0;
                            btn_release[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        state[i] <= STABLE_LO;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef LONG_PRESS_EN
    // Counter parks at LONG_CYCLES so a single hold fires only once.
    always_ff @(posedge inCLK_50MHZ) begin
        if (!reset_n) begin
            btn_long <= '0;
            for (int i = 0; i < N_BTN; i++) long_cnt[i] <= '0;
        end else begin
            btn_long <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                if (state[i] != STABLE_HI) begin
                    long_cnt[i] <= '0;
                end else if (long_cnt[i] != LONG_W'(LONG_CYCLES)) begin
                    long_cnt[i] <= long_cnt[i] + 1'b1;
                    btn_long[i] <= (long_cnt[i] == LONG_W'(LONG_CYCLES - 1));
                end
            end
        end
    end
`endif

    function automatic logic [ID_W-1:0] lowest_idx(input logic [N_BTN-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

    assign ack_fire = evt_valid && evt_ack;

    always_comb begin
        ack_clr = '0;
        if (ack_fire) ack_clr[evt_id] = 1'b1;
    end

    // A fresh press on the acked channel wins over the clear.
    always_ff @(posedge inCLK_50MHZ) begin
        if (!reset_n) begin
            pend         <= '0;
            evt_valid    <= 1'b0;
            evt_id       <= '0;
            evt_overflow <= '0;
        end else begin
            pend         <= (pend & ~ack_clr) | press_acc;
            evt_overflow <= evt_overflow | (press_acc & pend);
            if (ack_fire) begin
                evt_valid <= 1'b0;
            end else if (!evt_valid && (pend != '0)) begin
                evt_valid <= 1'b1;
                evt_id    <= lowest_idx(pend);
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Scoreboard bench for btn_debounce_bank: a sliding-window reference model predicts
// every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_btn_debounce_bank;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic         evt_ack = 1'b0;
    logic [N-1:0] btn_level, btn_press, btn_release, evt_overflow;
    logic         evt_valid;
    logic [1:0]   evt_id;
`ifdef LONG_PRESS_EN
    logic [N-1:0] btn_long;
`endif

    always #10 clk = ~clk;

    btn_debounce_bank #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(3), .ID_W(2)
`ifdef LONG_PRESS_EN
        ,.LONG_CYCLES(10)
`endif
    ) dut (
        .inCLK_50MHZ (clk),
        .reset_n     (reset_n),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .evt_ack     (evt_ack),
        .evt_overflow(evt_overflow)
`ifdef LONG_PRESS_EN
        ,.btn_long   (btn_long)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
    endfunction

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic         valid;
        logic [1:0]   id;
        logic [N-1:0] ovf;
    } obs_t;

    obs_t exp_q[$];

    // Reference model: a change is accepted once the last D synchronised samples
    // all disagree with the current level; events go out lowest-pending-first.
    logic [N-1:0] m_syn1 = '0, m_syn2 = '0, m_level = '0, m_pend = '0, m_ovf = '0;
    logic         m_valid = 1'b0;
    logic [1:0]   m_id = '0;
    logic [D-1:0] hist [N];
    int           nval [N];

    function automatic logic [1:0] first_set(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return 2'(k);
        return 2'd0;
    endfunction

    always @(posedge clk) begin : model
        obs_t         e;
        logic [N-1:0] s, press, rel, new_pend;
        logic [D-1:0] target;
        logic         ack_fire;
        press = '0;
        rel   = '0;
        if (!reset_n) begin
            m_syn1 = '0; m_syn2 = '0; m_level = '0; m_pend = '0; m_ovf = '0;
            m_valid = 1'b0; m_id = '0;
            for (int c = 0; c < N; c++) begin hist[c] = '0; nval[c] = 0; end
        end else begin
            s = m_syn2;
            m_syn2 = m_syn1;
            m_syn1 = btn_in;
            for (int c = 0; c < N; c++) begin
                hist[c] = {hist[c][D-2:0], s[c]};
                if (nval[c] < D) nval[c]++;
                target = m_level[c] ? '0 : '1;
                if (nval[c] == D && hist[c] == target) begin
                    m_level[c] = ~m_level[c];
                    if (m_level[c]) press[c] = 1'b1;
                    else rel[c] = 1'b1;
                end
            end
            ack_fire = m_valid && evt_ack;
            m_ovf = m_ovf | (press & m_pend);
            new_pend = m_pend;
            if (ack_fire) new_pend[m_id] = 1'b0;
            new_pend = new_pend | press;
            if (ack_fire) m_valid = 1'b0;
            else if (!m_valid && m_pend != '0) begin
                m_valid = 1'b1;
                m_id = first_set(m_pend);
            end
            m_pend = new_pend;
        end
        e.level = m_level; e.press = press; e.rel = rel;
        e.valid = m_valid; e.id = m_id; e.ovf = m_ovf;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("debounce_outputs", {20'd0, btn_level, btn_press, btn_release},
                  {20'd0, e.level, e.press, e.rel});
            check("event_outputs", {25'd0, evt_valid, evt_id, evt_overflow},
                  {25'd0, e.valid, e.id, e.ovf});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!evt_valid && n < 30) begin @(negedge clk); n++; end
        check(name, 32'(evt_valid), 32'd1);
    endtask

    task automatic ack_once();
        evt_ack = 1'b1;
        tick(1);
        evt_ack = 1'b0;
    endtask

    int lat;
    int hold [N];

    initial begin
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(20);
        check("idle_level", 32'(btn_level), 32'd0);
        check("idle_valid", 32'(evt_valid), 32'd0);
        check("idle_overflow", 32'(evt_overflow), 32'd0);

        // Clean press on channel 0: latency measured in rising edges.
        btn_in[0] = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!btn_press[0] && lat < 20);
        check("press_latency", 32'(lat), 32'd6);
        check("level_with_press", 32'(btn_level[0]), 32'd1);
        @(negedge clk);
        wait_valid("ch0_valid");
        check("ch0_id", 32'(evt_id), 32'd0);
        ack_once();
        check("ch0_dropped", 32'(evt_valid), 32'd0);

        // Glitch shorter than the debounce window on channel 2.
        btn_in[2] = 1'b1;
        tick(3);
        btn_in[2] = 1'b0;
        tick(10);
        check("glitch_level", 32'(btn_level[2]), 32'd0);
        check("glitch_no_event", 32'(evt_valid), 32'd0);
        btn_in[0] = 1'b0;
        tick(10);

        // Simultaneous presses on channels 1 and 3 delivered in index order.
        btn_in[1] = 1'b1;
        btn_in[3] = 1'b1;
        wait_valid("dual_first_valid");
        check("dual_first_id", 32'(evt_id), 32'd1);
        ack_once();
        wait_valid("dual_second_valid");
        check("dual_second_id", 32'(evt_id), 32'd3);
        ack_once();
        btn_in[1] = 1'b0;
        btn_in[3] = 1'b0;
        tick(10);

        // Second press on channel 1 while its event is still pending.
        btn_in[1] = 1'b1; tick(8);
        btn_in[1] = 1'b0; tick(8);
        btn_in[1] = 1'b1; tick(8);
        check("overflow_set", 32'(evt_overflow), 32'h2);
        wait_valid("ovf_valid");
        check("ovf_id", 32'(evt_id), 32'd1);
        ack_once();
        tick(5);
        check("ovf_single_event", 32'(evt_valid), 32'd0);
        btn_in[1] = 1'b0;
        tick(10);

        // Reset in the middle of channel 0's pending-high window.
        btn_in[0] = 1'b1;
        tick(4);
        reset_n = 1'b0;
        btn_in[0] = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(10);
        check("reset_clears_overflow", 32'(evt_overflow), 32'd0);
        check("reset_no_level", 32'(btn_level), 32'd0);

        // Randomised holds (some shorter than the window), random acks, rare resets.
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    btn_in[c] = 1'($urandom_range(0, 1));
                    hold[c] = int'($urandom_range(1, 12));
                end else begin
                    hold[c]--;
                end
            end
            evt_ack = ($urandom_range(0, 3) == 0);
            reset_n = ($urandom_range(0, 499) != 0);
            tick(1);
        end
        evt_ack = 1'b0;
        reset_n = 1'b1;
        btn_in = '0;
        tick(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
